// File: rtl/ttt_game_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ttt_game_ctrl_if : move request / new-game / ack-nack handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface ttt_game_ctrl_if;
  logic       i_move_vld;
  logic [1:0] i_move_row;
  logic [1:0] i_move_col;
  logic       i_new_game;
  logic       o_move_ack;
  logic       o_move_nack;

  modport master (
    output i_move_vld, i_move_row, i_move_col, i_new_game,
    input  o_move_ack, o_move_nack
  );

  modport slave (
    input  i_move_vld, i_move_row, i_move_col, i_new_game,
    output o_move_ack, o_move_nack
  );
endinterface
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ttt_game_ctrl : tic-tac-toe move arbiter, win/draw detector, score keeper
// Macro TTT_SCORE_EN enables the saturating per-player win counters.
// Rev 1.0
// ---------------------------------------------------------------------------
module ttt_game_ctrl #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic             CLK,
  input  logic             rst,
  ttt_game_ctrl_if.slave   mv,
  output logic [8:0]       o_board_p1,
  output logic [8:0]       o_board_p2,
  output logic             o_player,
  output logic [1:0]       o_state,
  output logic [1:0]       o_winner,
  output logic [7:0]       o_win_line,
  output logic [3:0]       o_score_p1,
  output logic [3:0]       o_score_p2
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] board_p1_q, board_p1_d;
  logic [8:0] board_p2_q, board_p2_d;
  logic       player_q, player_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] win_line_q, win_line_d;
  logic       ack_q, ack_d;
  logic       nack_q, nack_d;
`ifdef TTT_SCORE_EN
  logic [3:0] score_p1_q, score_p1_d;
  logic [3:0] score_p2_q, score_p2_d;
`endif

  logic       coord_ok;
  logic [3:0] move_idx;
  logic [8:0] move_mask;
  logic [8:0] mover_board;
  logic [7:0] lines;

  assign coord_ok    = (mv.i_move_row != 2'd0) && (mv.i_move_col != 2'd0);
  assign move_idx    = ({2'b00, mv.i_move_row - 2'd1} * 4'd3) + {2'b00, mv.i_move_col - 2'd1};
  assign move_mask   = 9'd1 << move_idx;
  assign mover_board = player_q ? board_p2_q : board_p1_q;

  // Only the mover can have completed a line, so the other board is ignored.
  assign lines[0] = &{mover_board[0], mover_board[1], mover_board[2]};
  assign lines[1] = &{mover_board[3], mover_board[4], mover_board[5]};
  assign lines[2] = &{mover_board[6], mover_board[7], mover_board[8]};
  assign lines[3] = &{mover_board[0], mover_board[3], mover_board[6]};
  assign lines[4] = &{mover_board[1], mover_board[4], mover_board[7]};
  assign lines[5] = &{mover_board[2], mover_board[5], mover_board[8]};
  assign lines[6] = &{mover_board[0], mover_board[4], mover_board[8]};
  assign lines[7] = &{mover_board[2], mover_board[4], mover_board[6]};

  always_comb begin
    state_d    = state_q;
    board_p1_d = board_p1_q;
    board_p2_d = board_p2_q;
    player_d   = player_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    ack_d      = 1'b0;
    nack_d     = 1'b0;
`ifdef TTT_SCORE_EN
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
`endif
    if (mv.i_new_game) begin
      state_d    = ST_PLAY;
      board_p1_d = 9'd0;
      board_p2_d = 9'd0;
      player_d   = FIRST_PLAYER;
      winner_d   = 2'b00;
      win_line_d = 8'd0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (mv.i_move_vld) begin
            if (coord_ok && ((board_p1_q | board_p2_q) & move_mask) == 9'd0) begin
              if (player_q) board_p2_d = board_p2_q | move_mask;
              else          board_p1_d = board_p1_q | move_mask;
              ack_d   = 1'b1;
              state_d = ST_CHECK;
            end else begin
              nack_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          nack_d = mv.i_move_vld;
          if (|lines) begin
            state_d    = ST_OVER;
            winner_d   = player_q ? 2'b10 : 2'b01;
            win_line_d = lines;
`ifdef TTT_SCORE_EN
            if (player_q) begin
              if (score_p2_q != 4'hF) score_p2_d = score_p2_q + 4'd1;
            end else begin
              if (score_p1_q != 4'hF) score_p1_d = score_p1_q + 4'd1;
            end
`endif
          end else if (&(board_p1_q | board_p2_q)) begin
            state_d    = ST_OVER;
            winner_d   = 2'b11;
            win_line_d = 8'd0;
          end else begin
            player_d = ~player_q;
            state_d  = ST_PLAY;
          end
        end
        ST_OVER: nack_d = mv.i_move_vld;
        default: state_d = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_PLAY;
      board_p1_q <= 9'd0;
      board_p2_q <= 9'd0;
      player_q   <= FIRST_PLAYER;
      winner_q   <= 2'b00;
      win_line_q <= 8'd0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
`ifdef TTT_SCORE_EN
      score_p1_q <= 4'd0;
      score_p2_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      board_p1_q <= board_p1_d;
      board_p2_q <= board_p2_d;
      player_q   <= player_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
`ifdef TTT_SCORE_EN
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
`endif
    end
  end

  assign o_board_p1     = board_p1_q;
  assign o_board_p2     = board_p2_q;
  assign o_player       = player_q;
  assign o_state        = state_q;
  assign o_winner       = winner_q;
  assign o_win_line     = win_line_q;
  assign mv.o_move_ack  = ack_q;
  assign mv.o_move_nack = nack_q;
`ifdef TTT_SCORE_EN
  assign o_score_p1 = score_p1_q;
  assign o_score_p2 = score_p2_q;
`else
  assign o_score_p1 = 4'd0;
  assign o_score_p2 = 4'd0;
`endif

endmodule
`default_nettype wire

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter FIRST_PLAYER, default 0, the player who moves first after reset or new game (0=P1, 1=P2).
REQ-002 CLK  input  1  system clock; every flop is clocked on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_move_vld  input  1  single-cycle move request strobe, driven from a debounced button edge.
REQ-005 i_move_row  input  2  target row 1..3; value 0 is illegal.
REQ-006 i_move_col  input  2  target column 1..3; value 0 is illegal.
REQ-007 i_new_game  input  1  single-cycle request to clear the board and restart the game.
REQ-008 o_board_p1  output  9  P1 occupancy; bit index = (row-1)*3 + (col-1).
REQ-009 o_board_p2  output  9  P2 occupancy, same indexing as o_board_p1.
REQ-010 o_player  output  1  player to move (0=P1, 1=P2).
REQ-011 o_move_ack / o_move_nack  output  1 each  single-cycle accept / reject pulses.
REQ-012 o_state  output  2  00=PLAY, 01=CHECK, 10=OVER; value 11 is never driven.
REQ-013 o_winner  output  2  00=none, 01=P1, 10=P2, 11=draw.
REQ-014 o_win_line  output  8  one-hot winning line: bits 0-2 rows 1-3, bits 3-5 columns 1-3, bit 6 main diagonal (squares 0,4,8), bit 7 anti-diagonal (squares 2,4,6).
REQ-015 o_score_p1 / o_score_p2  output  4 each  games won per player.

Function
REQ-016 The controller SHALL be a three-state FSM (PLAY, CHECK, OVER), and all outputs SHALL be registered.
REQ-017 In PLAY, a request is legal when i_move_vld=1, row and column are both in 1..3, and the target bit is clear in both boards.
REQ-018 A legal request in cycle N SHALL set the mover's board bit, pulse o_move_ack and enter CHECK, all at N+1.
REQ-019 An illegal request (bad coordinate, occupied square, or any i_move_vld while in CHECK or OVER) SHALL pulse o_move_nack at N+1 and leave the board, player and state unchanged.
REQ-020 CHECK SHALL last exactly one cycle and evaluate all 8 lines against the mover's board only.
REQ-021 On a win, the block SHALL enter OVER with o_winner set to the mover and the o_win_line bit set for each completed line; multiple bits are legal on a double line.
REQ-022 If no line is complete and all 9 squares are occupied, the block SHALL enter OVER with o_winner=11 and o_win_line=0.
REQ-023 Otherwise the block SHALL toggle o_player and return to PLAY, so the next move is accepted no earlier than N+2.
REQ-024 A win on the 9th move SHALL be reported as a win, not a draw.
REQ-025 OVER SHALL hold the board, o_winner and o_win_line until i_new_game or rst.
REQ-026 In any state, i_new_game SHALL clear both boards, o_winner and o_win_line, set o_player=FIRST_PLAYER and o_state=PLAY on the next cycle.
REQ-027 i_new_game SHALL NOT clear the scores.
REQ-028 When i_new_game and i_move_vld coincide, i_new_game SHALL take priority; the move is discarded with no ack and no nack.
REQ-029 o_move_ack and o_move_nack SHALL never be high in the same cycle.

Reset
REQ-030 rst SHALL override every other input.
REQ-031 The cycle after rst is asserted: boards=0, o_player=FIRST_PLAYER, o_state=PLAY, o_winner=00, o_win_line=0, both ack/nack pulses=0, both scores=0.
REQ-032 A move presented in the same cycle as rst SHALL be dropped, including when rst arrives while the FSM is in CHECK.

Configuration
REQ-033 Macro TTT_SCORE_EN controls the score counters.
REQ-034 With TTT_SCORE_EN defined, entering OVER with a win SHALL increment the winner's score by 1, saturating at 15; a draw SHALL change neither score.
REQ-035 Without TTT_SCORE_EN, the score ports SHALL remain and be driven constant 0, and no counter logic SHALL be synthesized.

Verification
REQ-036 Moves (1,1) P1, (2,1) P2, (1,2) P1, (2,2) P2, (1,3) P1 -> o_winner=01, o_win_line=0x01, o_state=10; with TTT_SCORE_EN, o_score_p1=1.
REQ-037 A move to (1,1) by P1, then a move to (1,1) by P2 -> second move gets o_move_nack, o_board_p2=0, o_player stays 1; a move to (0,2) -> nack.
REQ-038 Fill all 9 squares with no line complete -> o_winner=11, o_win_line=0; a further i_move_vld -> nack.
REQ-039 i_new_game and i_move_vld in the same cycle while in OVER -> boards=0, state PLAY, no ack or nack, scores kept.
REQ-040 rst asserted in the CHECK cycle that follows a winning move -> all outputs at reset values the next cycle and both scores=0.
REQ-041 With TTT_SCORE_EN, 16 P2 wins -> o_score_p2 saturates at 15.
